// File: rtl/bp_mem_transducer_pipelined.sv
// Bridges CCE memory command/response messages onto a block-wide, byte-masked memory port.
// Up to els_p commands may be outstanding; responses come back in issue order.
module bp_mem_transducer_pipelined #(
   parameter int unsigned paddr_width_p     = 40,
   parameter int unsigned cce_block_width_p = 512,
   parameter int unsigned dword_width_p     = 64,
   parameter int unsigned payload_width_p   = 16,
   parameter logic [paddr_width_p-1:0] dram_offset_p = '0,
   parameter int unsigned els_p             = 4,
   localparam int unsigned msg_type_width_lp    = 4,
   localparam int unsigned size_width_lp        = 3,
   localparam int unsigned header_width_lp      =
      msg_type_width_lp + paddr_width_p + size_width_lp + payload_width_p,
   localparam int unsigned cce_mem_msg_width_lp = header_width_lp + cce_block_width_p,
   localparam int unsigned ptr_width_lp         = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int unsigned cnt_width_lp         = $clog2(els_p + 1)
) (
   input  logic                              clk_i,
   input  logic                              reset_i,

   input  logic [cce_mem_msg_width_lp-1:0]   mem_cmd_i,
   input  logic                              mem_cmd_v_i,
   output logic                              mem_cmd_ready_o,

   output logic [cce_mem_msg_width_lp-1:0]   mem_resp_o,
   output logic                              mem_resp_v_o,
   input  logic                              mem_resp_yumi_i,

   input  logic                              ready_i,
   output logic                              v_o,
   output logic                              w_o,
   output logic [paddr_width_p-1:0]          addr_o,
   output logic [cce_block_width_p-1:0]      data_o,
   output logic [cce_block_width_p/8-1:0]    write_mask_o,

   input  logic [cce_block_width_p-1:0]      data_i,
   input  logic                              v_i,
   output logic                              yumi_o
);

   localparam int unsigned block_bytes_lp    = cce_block_width_p / 8;
   localparam int unsigned lg_block_bytes_lp = $clog2(block_bytes_lp);
   localparam int unsigned lg_dword_bytes_lp = $clog2(dword_width_p / 8);
   localparam int unsigned lg_block_words_lp = $clog2(cce_block_width_p / dword_width_p);
   localparam int unsigned shift_width_lp    = lg_block_words_lp + lg_dword_bytes_lp + 3;

   // Cached reads (encoding 0) and any other type pass through without special handling.
   localparam logic [msg_type_width_lp-1:0] e_cce_mem_wr    = 4'd1;
   localparam logic [msg_type_width_lp-1:0] e_cce_mem_uc_rd = 4'd2;
   localparam logic [msg_type_width_lp-1:0] e_cce_mem_uc_wr = 4'd3;

   typedef struct packed {
      logic [payload_width_p-1:0]   payload;
      logic [size_width_lp-1:0]     size;
      logic [paddr_width_p-1:0]     addr;
      logic [msg_type_width_lp-1:0] msg_type;
   } header_s;

   header_s                        cmd_header;
   header_s                        head_header;
   logic [cce_block_width_p-1:0]   cmd_data;
   logic [cce_block_width_p-1:0]   resp_data;
   logic [paddr_width_p-1:0]       addr_adj;
   logic [shift_width_lp-1:0]      cmd_shift;
   logic [shift_width_lp-1:0]      head_shift;

   header_s                        fifo_q [els_p];
   logic [ptr_width_lp-1:0]        wptr_q, wptr_d;
   logic [ptr_width_lp-1:0]        rptr_q, rptr_d;
   logic [cnt_width_lp-1:0]        count_q, count_d;
   logic                           full;
   logic                           enq;
   logic                           deq;

   assign cmd_header = header_s'(mem_cmd_i[header_width_lp-1:0]);
   assign cmd_data   = mem_cmd_i[cce_mem_msg_width_lp-1:header_width_lp];

   // Handshakes: ready never depends on this cycle's yumi, so a full FIFO stalls one cycle.
   assign full            = (count_q == cnt_width_lp'(els_p));
   assign mem_cmd_ready_o = ready_i & ~full & ~reset_i;
   assign v_o             = mem_cmd_v_i & mem_cmd_ready_o;
   assign enq             = v_o;
   assign mem_resp_v_o    = v_i & (count_q != '0) & ~reset_i;
   assign yumi_o          = mem_resp_yumi_i & ~reset_i;
   assign deq             = yumi_o & mem_resp_v_o;

   // Bit offset of the addressed byte inside the block: word_off * dword + byte_off * 8.
   assign cmd_shift  = {cmd_header.addr[lg_dword_bytes_lp +: lg_block_words_lp],
                        cmd_header.addr[0 +: lg_dword_bytes_lp], 3'b000};
   assign head_shift = {head_header.addr[lg_dword_bytes_lp +: lg_block_words_lp],
                        head_header.addr[0 +: lg_dword_bytes_lp], 3'b000};

   assign addr_adj = cmd_header.addr - dram_offset_p;
   assign addr_o   = addr_adj & ~paddr_width_p'(block_bytes_lp - 1);
   assign w_o      = v_o & ((cmd_header.msg_type == e_cce_mem_wr)
                           | (cmd_header.msg_type == e_cce_mem_uc_wr));
   assign data_o   = cmd_data << cmd_shift;

   always_comb begin
      write_mask_o = '1;
      if (cmd_header.size < size_width_lp'(lg_block_bytes_lp)) begin
         write_mask_o = ~({block_bytes_lp{1'b1}} << (32'd1 << cmd_header.size))
                        << cmd_shift[shift_width_lp-1:3];
      end
   end

   assign head_header = fifo_q[rptr_q];

   always_comb begin
      resp_data = data_i;
      if (head_header.msg_type == e_cce_mem_uc_rd) begin
         resp_data = (data_i >> head_shift)
                     & ~({cce_block_width_p{1'b1}} << (32'd8 << head_header.size));
      end
   end

   assign mem_resp_o = {resp_data, head_header};

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (enq) begin
         wptr_d = (wptr_q == ptr_width_lp'(els_p - 1)) ? '0 : wptr_q + ptr_width_lp'(1);
      end
      if (deq) begin
         rptr_d = (rptr_q == ptr_width_lp'(els_p - 1)) ? '0 : rptr_q + ptr_width_lp'(1);
      end
      unique case ({enq, deq})
         2'b10:   count_d = count_q + cnt_width_lp'(1);
         2'b01:   count_d = count_q - cnt_width_lp'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Header storage needs no reset; occupancy decides which entries are live.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         fifo_q[wptr_q] <= cmd_header;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(v_i && (count_q == '0)))
            else $error("memory response with no outstanding command");
         assert (!(mem_resp_yumi_i && !mem_resp_v_o))
            else $error("response consumed while not valid");
         assert (!(count_q > cnt_width_lp'(els_p)))
            else $error("occupancy above els_p");
      end
   end
`endif

endmodule

// File: tb/tb_bp_mem_transducer_pipelined.sv
// Scoreboard bench for bp_mem_transducer_pipelined: expected responses are queued at command
// acceptance and compared in order as the transducer hands them back.
module tb_bp_mem_transducer_pipelined;

   localparam int PW  = 40;
   localparam int BW  = 512;
   localparam int PLW = 16;
   localparam int HW  = 4 + PW + 3 + PLW;
   localparam int MW  = HW + BW;
   localparam int BB  = BW / 8;
   localparam logic [PW-1:0] OFFSET = 40'h00_8000_0000;
   localparam logic [3:0] RD = 4'd0, WR = 4'd1, UC_RD = 4'd2, UC_WR = 4'd3;

   logic          clk, reset;
   logic [MW-1:0] cmd, resp;
   logic          cmd_v, cmd_ready, resp_v, resp_yumi;
   logic          ready, req_v, req_w;
   logic [PW-1:0] req_addr;
   logic [BW-1:0] req_data, rdata;
   logic [BB-1:0] req_mask;
   logic          rvalid, ryumi;

   logic [MW-1:0] exp_q[$];
   logic [BW-1:0] mem_q[$];
   int checks = 0;
   int errors = 0;

   bp_mem_transducer_pipelined #(
      .paddr_width_p    (PW),
      .cce_block_width_p(BW),
      .dword_width_p    (64),
      .payload_width_p  (PLW),
      .dram_offset_p    (OFFSET),
      .els_p            (4)
   ) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .mem_cmd_i      (cmd),
      .mem_cmd_v_i    (cmd_v),
      .mem_cmd_ready_o(cmd_ready),
      .mem_resp_o     (resp),
      .mem_resp_v_o   (resp_v),
      .mem_resp_yumi_i(resp_yumi),
      .ready_i        (ready),
      .v_o            (req_v),
      .w_o            (req_w),
      .addr_o         (req_addr),
      .data_o         (req_data),
      .write_mask_o   (req_mask),
      .data_i         (rdata),
      .v_i            (rvalid),
      .yumi_o         (ryumi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [PW-1:0] a,
                                            input logic [2:0] s, input logic [PLW-1:0] p);
      return {p, s, a, t};
   endfunction

   function automatic logic [BW-1:0] rand_blk();
      logic [BW-1:0] r;
      for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [BW-1:0] model_resp(input logic [3:0] t, input logic [PW-1:0] a,
                                                input logic [2:0] s, input logic [BW-1:0] d);
      logic [BW-1:0] r;
      r = d;
      if (t == UC_RD) begin
         r = d >> (int'(a[5:0]) * 8);
         for (int i = 0; i < BW; i++) if (i >= (8 << s)) r[i] = 1'b0;
      end
      return r;
   endfunction

   function automatic logic [BB-1:0] model_mask(input logic [PW-1:0] a, input logic [2:0] s);
      logic [BB-1:0] m;
      int off, n;
      off = int'(a[5:0]);
      n   = 1 << s;
      m   = '0;
      if (s >= 3'd6) m = '1;
      else for (int i = 0; i < BB; i++) if (i >= off && i < off + n) m[i] = 1'b1;
      return m;
   endfunction

   task automatic idle_inputs();
      cmd_v = 1'b0; ready = 1'b0; rvalid = 1'b0; resp_yumi = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; cmd = {BW'(0), mk_hdr(WR, OFFSET, 3'd6, 16'h0)};
      cmd_v = 1'b1; ready = 1'b1; rvalid = 1'b1; resp_yumi = 1'b1; rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
      checks++; if (req_v !== 1'b0) begin errors++; $display("FAIL reset_v: got %b want 0", req_v); end
      checks++; if (req_w !== 1'b0) begin errors++; $display("FAIL reset_w: got %b want 0", req_w); end
      checks++; if (resp_v !== 1'b0) begin errors++; $display("FAIL reset_resp_v: got %b want 0", resp_v); end
      checks++; if (ryumi !== 1'b0) begin errors++; $display("FAIL reset_yumi: got %b want 0", ryumi); end
      @(negedge clk); reset = 1'b0; idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_single_read();
      logic [HW-1:0] h; logic [BW-1:0] d; logic [MW-1:0] e;
      @(negedge clk);
      h = mk_hdr(RD, 40'h00_8000_0040, 3'd6, 16'h0101);
      cmd = {BW'(0), h}; cmd_v = 1'b1; ready = 1'b1; #1;
      checks++; if (req_v !== 1'b1) begin errors++; $display("FAIL rd_v: got %b want 1", req_v); end
      checks++; if (req_w !== 1'b0) begin errors++; $display("FAIL rd_w: got %b want 0", req_w); end
      checks++; if (req_addr !== 40'h40) begin errors++; $display("FAIL rd_addr: got %h want 40", req_addr); end
      d = rand_blk(); exp_q.push_back({d, h}); mem_q.push_back(d);
      @(negedge clk); cmd_v = 1'b0; ready = 1'b0; rvalid = 1'b1; rdata = mem_q[0]; #1;
      checks++; if (resp_v !== 1'b1) begin errors++; $display("FAIL rd_resp_v: got %b want 1", resp_v); end
      resp_yumi = 1'b1; #1;
      checks++; if (ryumi !== 1'b1) begin errors++; $display("FAIL rd_yumi: got %b want 1", ryumi); end
      e = exp_q.pop_front(); void'(mem_q.pop_front());
      checks++; if (resp !== e) begin errors++; $display("FAIL rd_resp: got %h want %h", resp, e); end
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_uc_read();
      logic [HW-1:0] h; logic [BW-1:0] d; logic [MW-1:0] e;
      @(negedge clk);
      h = mk_hdr(UC_RD, 40'h00_8000_000C, 3'd2, 16'h0202);
      cmd = {BW'(0), h}; cmd_v = 1'b1; ready = 1'b1; #1;
      checks++; if (req_addr !== 40'h0) begin errors++; $display("FAIL ucrd_addr: got %h want 0", req_addr); end
      d = rand_blk(); d[127:64] = 64'hAABBCCDD_11223344;
      exp_q.push_back({BW'(64'h00000000_AABBCCDD), h}); mem_q.push_back(d);
      @(negedge clk); cmd_v = 1'b0; ready = 1'b0; rvalid = 1'b1; rdata = mem_q[0]; #1;
      resp_yumi = resp_v; #1;
      e = exp_q.pop_front(); void'(mem_q.pop_front());
      checks++; if (resp !== e) begin errors++; $display("FAIL ucrd_resp: got %h want %h", resp, e); end
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_uc_write();
      logic [HW-1:0] h; logic [BW-1:0] d; logic [MW-1:0] e; logic [BB-1:0] m; logic [BW-1:0] w;
      @(negedge clk);
      h = mk_hdr(UC_WR, 40'h00_8000_0012, 3'd1, 16'h0303);
      cmd = {BW'(16'hBEEF), h}; cmd_v = 1'b1; ready = 1'b1; #1;
      m = 64'h3; m = m << 18; w = BW'(16'hBEEF); w = w << 144;
      checks++; if (req_w !== 1'b1) begin errors++; $display("FAIL ucwr_w: got %b want 1", req_w); end
      checks++; if (req_mask !== m) begin errors++; $display("FAIL ucwr_mask: got %h want %h", req_mask, m); end
      checks++; if (req_data[159:144] !== 16'hBEEF) begin errors++; $display("FAIL ucwr_bytes: got %h want beef", req_data[159:144]); end
      checks++; if (req_data !== w) begin errors++; $display("FAIL ucwr_data: got %h want %h", req_data, w); end
      d = rand_blk(); exp_q.push_back({d, h}); mem_q.push_back(d);
      @(negedge clk); cmd_v = 1'b0; ready = 1'b0; rvalid = 1'b1; rdata = mem_q[0]; #1;
      resp_yumi = resp_v; #1;
      e = exp_q.pop_front(); void'(mem_q.pop_front());
      checks++; if (resp !== e) begin errors++; $display("FAIL ucwr_resp: got %h want %h", resp, e); end
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_fill_full();
      logic [HW-1:0] h; logic [BW-1:0] d; logic [MW-1:0] e;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         h = mk_hdr(RD, OFFSET + PW'(k * 64), 3'd6, PLW'(16'h10 + k));
         cmd = {BW'(0), h}; cmd_v = 1'b1; ready = 1'b1; #1;
         checks++; if (req_v !== 1'b1) begin errors++; $display("FAIL fill_v%0d: got %b want 1", k, req_v); end
         d = rand_blk(); exp_q.push_back({d, h}); mem_q.push_back(d);
      end
      @(negedge clk);
      h = mk_hdr(RD, OFFSET + PW'(4 * 64), 3'd6, 16'h14);
      cmd = {BW'(0), h}; rvalid = 1'b1; rdata = mem_q[0]; #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
      checks++; if (req_v !== 1'b0) begin errors++; $display("FAIL full_v: got %b want 0", req_v); end
      resp_yumi = resp_v; #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_deq_ready: got %b want 0", cmd_ready); end
      e = exp_q.pop_front(); void'(mem_q.pop_front());
      checks++; if (resp !== e) begin errors++; $display("FAIL full_resp: got %h want %h", resp, e); end
      @(negedge clk); rvalid = 1'b0; resp_yumi = 1'b0; #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL refill_ready: got %b want 1", cmd_ready); end
      checks++; if (req_v !== 1'b1) begin errors++; $display("FAIL refill_v: got %b want 1", req_v); end
      d = rand_blk(); exp_q.push_back({d, h}); mem_q.push_back(d);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); cmd_v = 1'b0; ready = 1'b0; resp_yumi = 1'b0;
         rvalid = 1'b1; rdata = mem_q[0]; #1;
         checks++; if (resp_v !== 1'b1) begin errors++; $display("FAIL drain_v%0d: got %b want 1", k, resp_v); end
         resp_yumi = 1'b1; #1;
         e = exp_q.pop_front(); void'(mem_q.pop_front());
         checks++; if (resp !== e) begin errors++; $display("FAIL drain_resp%0d: got %h want %h", k, resp, e); end
      end
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_wrap_ordering();
      logic [3:0] ct[10]; logic [PW-1:0] ca[10]; logic [2:0] cs[10]; logic [BW-1:0] cd[10];
      logic [HW-1:0] h; logic [BW-1:0] d; logic [MW-1:0] e; logic exp_ready;
      int idx, cyc;
      for (int k = 0; k < 10; k++) begin
         ct[k] = 4'($urandom_range(0, 3));
         cs[k] = (ct[k] == RD || ct[k] == WR) ? 3'd6 : 3'($urandom_range(0, 3));
         ca[k] = OFFSET + PW'($urandom_range(0, 4095));
         ca[k] = ca[k] & ~PW'((1 << cs[k]) - 1);
         cd[k] = rand_blk();
      end
      idx = 0; cyc = 0;
      while ((idx < 10 || exp_q.size() > 0) && cyc < 2000) begin
         @(negedge clk); cyc++;
         resp_yumi = 1'b0;
         cmd_v = (idx < 10);
         if (idx < 10) cmd = {cd[idx], mk_hdr(ct[idx], ca[idx], cs[idx], PLW'(idx))};
         ready = ($urandom_range(0, 3) != 0);
         rvalid = (mem_q.size() > 0) && ($urandom_range(0, 2) != 0);
         rdata = (mem_q.size() > 0) ? mem_q[0] : '0;
         #1;
         resp_yumi = resp_v && ($urandom_range(0, 2) != 0);
         #1;
         exp_ready = ready && (exp_q.size() < 4);
         checks++; if (cmd_ready !== exp_ready) begin errors++; $display("FAIL wrap_ready c%0d: got %b want %b", cyc, cmd_ready, exp_ready); end
         checks++; if (resp_v !== (rvalid && exp_q.size() > 0)) begin errors++; $display("FAIL wrap_resp_v c%0d: got %b want %b", cyc, resp_v, rvalid && exp_q.size() > 0); end
         if (req_v === 1'b1 && idx < 10) begin
            checks++; if (req_w !== (ct[idx] == WR || ct[idx] == UC_WR)) begin errors++; $display("FAIL wrap_w%0d: got %b want %b", idx, req_w, ct[idx] == WR || ct[idx] == UC_WR); end
            checks++; if (req_addr !== ((ca[idx] - OFFSET) & ~40'h3F)) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", idx, req_addr, (ca[idx] - OFFSET) & ~40'h3F); end
            if (ct[idx] == WR || ct[idx] == UC_WR) begin
               checks++; if (req_mask !== model_mask(ca[idx], cs[idx])) begin errors++; $display("FAIL wrap_mask%0d: got %h want %h", idx, req_mask, model_mask(ca[idx], cs[idx])); end
               checks++; if (req_data !== (cd[idx] << (int'(ca[idx][5:0]) * 8))) begin errors++; $display("FAIL wrap_wdata%0d: got %h want %h", idx, req_data, cd[idx] << (int'(ca[idx][5:0]) * 8)); end
            end
            h = mk_hdr(ct[idx], ca[idx], cs[idx], PLW'(idx));
            d = rand_blk();
            exp_q.push_back({model_resp(ct[idx], ca[idx], cs[idx], d), h});
            mem_q.push_back(d);
            idx++;
         end
         if (resp_yumi === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); void'(mem_q.pop_front());
            checks++; if (resp !== e) begin errors++; $display("FAIL wrap_resp c%0d: got %h want %h", cyc, resp, e); end
         end
      end
      checks++;
      if (idx != 10 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_done: got %0d issued %0d pending want 10 issued 0 pending", idx, exp_q.size());
      end
      @(negedge clk); idle_inputs();
      exp_q.delete(); mem_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [HW-1:0] h; logic [BW-1:0] d; logic [MW-1:0] e;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         h = mk_hdr(RD, OFFSET + PW'(k * 128), 3'd6, PLW'(16'h30 + k));
         cmd = {BW'(0), h}; cmd_v = 1'b1; ready = 1'b1; #1;
         checks++; if (req_v !== 1'b1) begin errors++; $display("FAIL pre_rst_v%0d: got %b want 1", k, req_v); end
         d = rand_blk(); exp_q.push_back({d, h}); mem_q.push_back(d);
      end
      @(negedge clk);
      reset = 1'b1; cmd = {BW'(0), mk_hdr(WR, OFFSET, 3'd6, 16'h3F)};
      cmd_v = 1'b1; ready = 1'b1; rvalid = 1'b1; rdata = mem_q[0]; resp_yumi = 1'b1;
      exp_q.delete(); mem_q.delete();
      repeat (2) begin
         #1;
         checks++; if ({cmd_ready, req_v, req_w, resp_v, ryumi} !== 5'b0) begin errors++; $display("FAIL mid_rst_outs: got %b want 00000", {cmd_ready, req_v, req_w, resp_v, ryumi}); end
         @(negedge clk);
      end
      reset = 1'b0; idle_inputs();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         h = mk_hdr(UC_RD, OFFSET + PW'(k * 64 + 8), 3'd3, PLW'(16'h40 + k));
         cmd = {BW'(0), h}; cmd_v = 1'b1; ready = 1'b1; #1;
         checks++; if (req_v !== (k < 4)) begin errors++; $display("FAIL post_rst_v%0d: got %b want %b", k, req_v, k < 4); end
         if (k < 4) begin
            d = rand_blk(); exp_q.push_back({model_resp(UC_RD, OFFSET + PW'(k * 64 + 8), 3'd3, d), h});
            mem_q.push_back(d);
         end
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); cmd_v = 1'b0; ready = 1'b0; resp_yumi = 1'b0;
         rvalid = 1'b1; rdata = mem_q[0]; #1;
         resp_yumi = resp_v; #1;
         e = exp_q.pop_front(); void'(mem_q.pop_front());
         checks++; if (resp !== e) begin errors++; $display("FAIL post_rst_resp%0d: got %h want %h", k, resp, e); end
      end
      @(negedge clk); idle_inputs();
   endtask

   initial begin
      reset = 1'b1; cmd = '0; rdata = '0; idle_inputs();
      test_reset();
      test_single_read();
      test_uc_read();
      test_uc_write();
      test_fill_full();
      test_wrap_ordering();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
